// File: rtl/pkt_switch_pkg.sv
// Shared types for the packet grant controller: port encoding and FSM states.
package pkt_switch_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      PORTA = 2'b01,
      PORTB = 2'b10,
      PORTC = 2'b11
   } port_e;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/rr_next_port.sv
// Combinational round-robin pick: the port after last_owner in A->B->C order that is requesting.
module rr_next_port
   import pkt_switch_pkg::*;
(
   input  logic [1:0] last_owner,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       req_c,
   output logic [1:0] next_port
);

   always_comb begin
      next_port = NONE;
      case (port_e'(last_owner))
         PORTA: begin
            if (req_b)      next_port = PORTB;
            else if (req_c) next_port = PORTC;
            else if (req_a) next_port = PORTA;
         end
         PORTB: begin
            if (req_c)      next_port = PORTC;
            else if (req_a) next_port = PORTA;
            else if (req_b) next_port = PORTB;
         end
         // Owner C, and the never-expected NONE, both start the search at A.
         default: begin
            if (req_a)      next_port = PORTA;
            else if (req_b) next_port = PORTB;
            else if (req_c) next_port = PORTC;
         end
      endcase
   end

endmodule

// File: rtl/packet_grant_ctrl.sv
// Grants a shared egress stream to one of three ports per packet, round-robin.
// Optional idle-beat watchdog enabled by defining ARB_TIMEOUT_EN.
module packet_grant_ctrl
   import pkt_switch_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_a,
   input  logic             req_b,
   input  logic             req_c,
   input  logic             out_valid,
   input  logic             out_ready,
   input  logic             out_last,
   output logic [1:0]       grant,
   output logic             busy,
   output logic             timeout,
   output logic [CNT_W-1:0] pkt_count,
   output logic             state_dbg
);

   // Egress handshake: a beat transfers when out_valid and out_ready are both
   // high on a rising edge; out_last marks the final beat of the owner's packet.
   logic last_beat;
   logic any_req;
   logic [1:0] rr_port;

   state_e           state_q, state_d;
   port_e            grant_q, grant_d;
   port_e            last_q, last_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

   assign last_beat = out_valid & out_ready & out_last;
   assign any_req   = req_a | req_b | req_c;

   // In HOLD last_q always equals the current owner, so one pick serves both
   // the IDLE grant and the same-cycle re-arbitration on a last beat.
   rr_next_port u_rr (
      .last_owner (last_q),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_c      (req_c),
      .next_port  (rr_port)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic            beat;
   logic            timeout_q, timeout_d;
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic [WD_W-1:0] wdog_inc;

   assign beat     = out_valid & out_ready;
   assign wdog_inc = wdog_q + WD_W'(1);
   assign timeout  = timeout_q;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;

   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      pkt_count_d = pkt_count_q;
`ifdef ARB_TIMEOUT_EN
      timeout_d   = 1'b0;
      wdog_d      = '0;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = HOLD;
               grant_d = port_e'(rr_port);
               last_d  = port_e'(rr_port);
            end
         end
         HOLD: begin
            if (last_beat) begin
               if (pkt_count_q != '1) pkt_count_d = pkt_count_q + CNT_W'(1);
               if (any_req) begin
                  grant_d = port_e'(rr_port);
                  last_d  = port_e'(rr_port);
               end else begin
                  state_d = IDLE;
                  grant_d = NONE;
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (beat) begin
               wdog_d = '0;
            end else if (wdog_inc == WD_W'(TIMEOUT_CYC)) begin
               // Forced release: the stalled owner goes to the back of the order.
               state_d   = IDLE;
               grant_d   = NONE;
               last_d    = grant_q;
               timeout_d = 1'b1;
            end else begin
               wdog_d = wdog_inc;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            grant_d = NONE;
         end
      endcase
      busy_d = (grant_d != NONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= NONE;
         last_q      <= PORTC;
         busy_q      <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         pkt_count_q <= pkt_count_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_q <= 1'b0;
         wdog_q    <= '0;
      end else begin
         timeout_q <= timeout_d;
         wdog_q    <= wdog_d;
      end
   end
`endif

   assign grant     = grant_q;
   assign busy      = busy_q;
   assign pkt_count = pkt_count_q;
   assign state_dbg = state_q;

endmodule
